// File: rtl/sprite_pkg.sv
// Shared sizes, palette type and FSM states for the sprite blitter.
package sprite_pkg;
   localparam int unsigned SPR_W      = 50;
   localparam int unsigned SPR_H      = 50;
   localparam int unsigned FB_W       = 640;
   localparam int unsigned FB_H       = 480;
   localparam int unsigned DATA_WIDTH = 3;
   localparam int unsigned ROM_ADDR_W = 12;
   localparam int unsigned FB_ADDR_W  = 19;
   localparam int unsigned SPR_N      = SPR_W * SPR_H;

   typedef logic [DATA_WIDTH-1:0] pal_idx_t;

   localparam pal_idx_t TRANSPARENT = '0;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} blit_state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// Control, sprite-ROM read and frame-buffer write signals of the blitter.
interface sprite_blitter_if
   import sprite_pkg::*;
();
   logic                  start;
   logic [9:0]            x0;
   logic [9:0]            y0;
   logic                  busy;
   logic                  done;
   logic [ROM_ADDR_W-1:0] rom_addr;
   pal_idx_t              rom_data;
   logic [FB_ADDR_W-1:0]  fb_addr;
   pal_idx_t              fb_data;
   logic                  fb_we;

   modport master (
      output start, x0, y0, rom_data,
      input  busy, done, rom_addr, fb_addr, fb_data, fb_we
   );

   modport slave (
      input  start, x0, y0, rom_data,
      output busy, done, rom_addr, fb_addr, fb_data, fb_we
   );
endinterface

// File: rtl/sprite_addr_gen.sv
// Running-counter address generator: ROM index, sprite column/row and frame-buffer address.
module sprite_addr_gen
   import sprite_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  i_clear,
   input  logic                  i_advance,
   input  logic [9:0]            i_x0,
   input  logic [9:0]            i_y0,
   output logic [ROM_ADDR_W-1:0] o_rom_addr,
   output logic [FB_ADDR_W-1:0]  o_fb_addr,
   output logic                  o_in_bounds,
   output logic                  o_last
);
   localparam int unsigned SxW = $clog2(SPR_W);
   localparam int unsigned SyW = $clog2(SPR_H);

   logic [SxW-1:0]        r_sx;
   logic [SyW-1:0]        r_sy;
   logic [ROM_ADDR_W-1:0] r_k;
   logic [20:0]           r_row_base;
   logic [9:0]            r_x0;
   logic [9:0]            r_y0;
   logic [10:0]           w_col;
   logic [10:0]           w_row;
   logic [20:0]           w_addr_full;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_sx       <= '0;
         r_sy       <= '0;
         r_k        <= '0;
         r_row_base <= '0;
         r_x0       <= '0;
         r_y0       <= '0;
      end else if (i_clear) begin
         r_x0       <= i_x0;
         r_y0       <= i_y0;
         r_sx       <= '0;
         r_sy       <= '0;
         r_k        <= '0;
         r_row_base <= 21'(i_y0) * 21'(FB_W);
      end else if (i_advance) begin
         r_k <= r_k + 1'b1;
         if (r_sx == SxW'(SPR_W - 1)) begin
            r_sx       <= '0;
            r_sy       <= r_sy + 1'b1;
            r_row_base <= r_row_base + 21'(FB_W);
         end else begin
            r_sx <= r_sx + 1'b1;
         end
      end
   end

   // 11-bit sums so a sprite hanging past column/row 1023 still clips correctly.
   assign w_col       = {1'b0, r_x0} + 11'(r_sx);
   assign w_row       = {1'b0, r_y0} + 11'(r_sy);
   assign w_addr_full = r_row_base + 21'(r_x0) + 21'(r_sx);

   assign o_rom_addr  = r_k;
   assign o_fb_addr   = w_addr_full[FB_ADDR_W-1:0];
   assign o_in_bounds = (w_col < 11'(FB_W)) && (w_row < 11'(FB_H));
   assign o_last      = (r_k == ROM_ADDR_W'(SPR_N - 1));
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: IDLE/RUN/FLUSH/DONE sequencer and the registered frame-buffer write stage.
module sprite_blitter
   import sprite_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   sprite_blitter_if.slave  bus
);
   blit_state_t          r_state;
   blit_state_t          w_state_next;
   logic                 w_clear;
   logic                 w_advance;
   logic                 w_in_bounds;
   logic                 w_last;
   logic                 w_wr;
   logic [FB_ADDR_W-1:0] w_gen_addr;
   logic                 r_fb_we;
   logic [FB_ADDR_W-1:0] r_fb_addr;
   pal_idx_t             r_fb_data;

   sprite_addr_gen u_addr_gen (
      .Clk         (Clk),
      .Reset       (Reset),
      .i_clear     (w_clear),
      .i_advance   (w_advance),
      .i_x0        (bus.x0),
      .i_y0        (bus.y0),
      .o_rom_addr  (bus.rom_addr),
      .o_fb_addr   (w_gen_addr),
      .o_in_bounds (w_in_bounds),
      .o_last      (w_last)
   );

   always_ff @(posedge Clk) begin
      if (!Reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_advance    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_clear      = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            w_advance = 1'b1;
            if (w_last) w_state_next = FLUSH;
         end
         FLUSH:   w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Write stage is one cycle behind rom_addr; address/data hold while not writing.
   assign w_wr = (r_state == RUN) && w_in_bounds && (bus.rom_data != TRANSPARENT);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_fb_we   <= 1'b0;
         r_fb_addr <= '0;
         r_fb_data <= '0;
      end else begin
         r_fb_we <= w_wr;
         if (w_wr) begin
            r_fb_addr <= w_gen_addr;
            r_fb_data <= bus.rom_data;
         end
      end
   end

   assign bus.busy    = (r_state == RUN) || (r_state == FLUSH);
   assign bus.done    = (r_state == DONE);
   assign bus.fb_we   = r_fb_we;
   assign bus.fb_addr = r_fb_addr;
   assign bus.fb_data = r_fb_data;
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: scoreboard of expected frame-buffer writes plus per-cycle timing.
module tb_sprite_blitter;
   import sprite_pkg::*;

   localparam int N = int'(SPR_N);

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   sprite_blitter_if bus ();

   sprite_blitter dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int edge_cnt = 0;
   always @(posedge Clk) edge_cnt <= edge_cnt + 1;

   logic rom_ones = 1'b0;
   assign bus.rom_data = rom_ones ? 3'b111 : bus.rom_addr[2:0];

   typedef struct {
      int addr;
      int data;
      int edge_no;
   } wr_t;

   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  wr_cnt = 0;
   int  done_cnt = 0;
   int  done_edge = 0;
   int  first_addr = 0;
   int  first_data = 0;
   int  last_addr = 0;
   bit  seen_first = 0;
   int  s1 = -1;
   int  s2 = -1;
   bit  mon_en = 0;
   bit  mon_quiet = 0;

   // Expected writes from div/mod pixel coordinates; pixel k lands on edge s+k+1.
   task automatic push_blit(input int x, input int y, input int s);
      for (int k = 0; k < N; k++) begin
         int col, row, d;
         col = x + k % int'(SPR_W);
         row = y + k / int'(SPR_W);
         d   = rom_ones ? 7 : k % 8;
         if (col < int'(FB_W) && row < int'(FB_H) && d != 0)
            exp_q.push_back('{(row * int'(FB_W) + col) % (1 << FB_ADDR_W), d, s + k + 1});
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge Clk);
         if (mon_en) begin
            int  c1, c2;
            bit  eb, ed;
            wr_t e;
            while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
               e = exp_q.pop_front();
               tests++;
               fails++;
               $display("FAIL missing_write addr=%0d edge=%0d got fb_we=0", e.addr, e.edge_no);
            end
            if (bus.fb_we === 1'b1) begin
               wr_cnt++;
               last_addr = int'(bus.fb_addr);
               if (!seen_first) begin
                  seen_first = 1;
                  first_addr = int'(bus.fb_addr);
                  first_data = int'(bus.fb_data);
               end
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_write edge=%0d addr=%0d data=%0d required no write",
                           edge_cnt, bus.fb_addr, bus.fb_data);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.fb_addr !== FB_ADDR_W'(e.addr) || bus.fb_data !== DATA_WIDTH'(e.data) ||
                      edge_cnt != e.edge_no) begin
                     fails++;
                     $display("FAIL write edge=%0d addr=%0d data=%0d required edge=%0d addr=%0d data=%0d",
                              edge_cnt, bus.fb_addr, bus.fb_data, e.edge_no, e.addr, e.data);
                  end
               end
            end
            if (!mon_quiet) begin
               c1 = (s1 < 0) ? -1 : edge_cnt - s1 + 1;
               c2 = (s2 < 0) ? -1 : edge_cnt - s2 + 1;
               eb = (c1 >= 1 && c1 <= N + 1) || (c2 >= 1 && c2 <= N + 1);
               ed = (c1 == N + 2) || (c2 == N + 2);
               tests++;
               if (bus.busy !== eb || bus.done !== ed) begin
                  fails++;
                  $display("FAIL busy_done edge=%0d busy=%b done=%b required busy=%b done=%b",
                           edge_cnt, bus.busy, bus.done, eb, ed);
               end
               if ((c1 >= 1 && c1 <= N) || (c2 >= 1 && c2 <= N)) begin
                  int er;
                  er = (c1 >= 1 && c1 <= N) ? c1 - 1 : c2 - 1;
                  tests++;
                  if (bus.rom_addr !== ROM_ADDR_W'(er)) begin
                     fails++;
                     $display("FAIL rom_addr edge=%0d got=%0d required=%0d", edge_cnt, bus.rom_addr, er);
                  end
               end
            end
            if (bus.done === 1'b1) begin
               done_cnt++;
               done_edge = edge_cnt;
            end
         end
      end
   endtask

   task automatic start_blit(input int x, input int y);
      wr_cnt     = 0;
      done_cnt   = 0;
      seen_first = 0;
      @(negedge Clk);
      bus.x0    = 10'(x);
      bus.y0    = 10'(y);
      bus.start = 1'b1;
      @(posedge Clk);
      #1;
      s1        = edge_cnt;
      bus.start = 1'b0;
      push_blit(x, y, s1);
   endtask

   task automatic wait_done(input int tgt, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk);
         #1;
         if (done_cnt >= tgt) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.x0    = '0;
      bus.y0    = '0;
      Reset     = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fb_we !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl busy=%b done=%b fb_we=%b required 0 0 0", bus.busy, bus.done, bus.fb_we);
      end
      tests++;
      if (bus.rom_addr !== '0 || bus.fb_addr !== '0 || bus.fb_data !== '0) begin
         fails++;
         $display("FAIL reset_addr rom=%0d fb=%0d data=%0d required 0 0 0",
                  bus.rom_addr, bus.fb_addr, bus.fb_data);
      end
      Reset  = 1'b1;
      mon_en = 1;
      repeat (5) @(negedge Clk);
   endtask

   task automatic test_origin();
      bit ok;
      rom_ones = 1'b0;
      start_blit(0, 0);
      wait_done(1, N + 10, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL origin_timeout done_cnt=%0d required 1", done_cnt); end
      repeat (5) @(negedge Clk);
      #1;
      tests++;
      if (wr_cnt != 2187) begin fails++; $display("FAIL origin_writes got=%0d required=2187", wr_cnt); end
      tests++;
      if (first_addr != 1 || first_data != 1) begin
         fails++;
         $display("FAIL origin_first addr=%0d data=%0d required addr=1 data=1", first_addr, first_data);
      end
      tests++;
      if (done_edge - s1 + 1 != N + 2) begin
         fails++;
         $display("FAIL origin_done_cycle got=%0d required=%0d", done_edge - s1 + 1, N + 2);
      end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL origin_drain left=%0d required 0", exp_q.size()); end
   endtask

   task automatic test_offset();
      bit ok;
      rom_ones = 1'b1;
      start_blit(100, 200);
      wait_done(1, N + 10, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL offset_timeout done_cnt=%0d required 1", done_cnt); end
      repeat (5) @(negedge Clk);
      #1;
      tests++;
      if (wr_cnt != 2500) begin fails++; $display("FAIL offset_writes got=%0d required=2500", wr_cnt); end
      tests++;
      if (first_addr != 128100 || last_addr != 159509) begin
         fails++;
         $display("FAIL offset_addr first=%0d last=%0d required 128100 159509", first_addr, last_addr);
      end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL offset_drain left=%0d required 0", exp_q.size()); end
   endtask

   task automatic test_clip();
      bit ok;
      rom_ones = 1'b1;
      start_blit(620, 470);
      wait_done(1, N + 10, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL clip_timeout done_cnt=%0d required 1", done_cnt); end
      repeat (5) @(negedge Clk);
      #1;
      tests++;
      if (wr_cnt != 200) begin fails++; $display("FAIL clip_writes got=%0d required=200", wr_cnt); end
      tests++;
      if (done_edge - s1 + 1 != N + 2) begin
         fails++;
         $display("FAIL clip_done_cycle got=%0d required=%0d", done_edge - s1 + 1, N + 2);
      end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL clip_drain left=%0d required 0", exp_q.size()); end
   endtask

   task automatic test_start_ignored();
      bit ok;
      rom_ones = 1'b1;
      start_blit(10, 20);
      while (edge_cnt < s1 + 99) @(negedge Clk);
      bus.start = 1'b1;
      bus.x0    = 10'd300;
      bus.y0    = 10'd100;
      @(negedge Clk);
      bus.start = 1'b0;
      wait_done(1, N + 10, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL ignore_timeout done_cnt=%0d required 1", done_cnt); end
      repeat (20) @(negedge Clk);
      #1;
      tests++;
      if (done_cnt != 1) begin fails++; $display("FAIL ignore_done_count got=%0d required=1", done_cnt); end
      tests++;
      if (wr_cnt != 2500) begin fails++; $display("FAIL ignore_writes got=%0d required=2500", wr_cnt); end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL ignore_drain left=%0d required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      rom_ones = 1'b1;
      start_blit(0, 0);
      while (edge_cnt < s1 + 998) begin
         @(posedge Clk);
         #1;
      end
      Reset     = 1'b0;
      mon_quiet = 1;
      @(posedge Clk);
      #1;
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fb_we !== 1'b0 || dut.r_state !== IDLE) begin
         fails++;
         $display("FAIL midreset_ctrl busy=%b done=%b fb_we=%b state=%0d required 0 0 0 IDLE",
                  bus.busy, bus.done, bus.fb_we, dut.r_state);
      end
      tests++;
      if (bus.rom_addr !== '0 || bus.fb_addr !== '0 || bus.fb_data !== '0) begin
         fails++;
         $display("FAIL midreset_addr rom=%0d fb=%0d data=%0d required 0 0 0",
                  bus.rom_addr, bus.fb_addr, bus.fb_data);
      end
      exp_q.delete();
      s1        = -1;
      mon_quiet = 0;
      Reset     = 1'b1;
      wr_cnt    = 0;
      repeat (50) @(negedge Clk);
      #1;
      tests++;
      if (wr_cnt != 0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL midreset_quiet writes=%0d busy=%b required 0 0", wr_cnt, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      rom_ones   = 1'b1;
      wr_cnt     = 0;
      done_cnt   = 0;
      seen_first = 0;
      @(negedge Clk);
      bus.x0    = 10'd5;
      bus.y0    = 10'd5;
      bus.start = 1'b1;
      @(posedge Clk);
      #1;
      s1 = edge_cnt;
      s2 = s1 + N + 3;
      push_blit(5, 5, s1);
      push_blit(5, 5, s2);
      while (edge_cnt < s2) begin
         @(posedge Clk);
         #1;
      end
      tests++;
      if (bus.rom_addr !== '0 || bus.busy !== 1'b1 || done_edge + 2 != edge_cnt) begin
         fails++;
         $display("FAIL b2b_restart rom=%0d busy=%b gap=%0d required rom=0 busy=1 gap=2",
                  bus.rom_addr, bus.busy, edge_cnt - done_edge);
      end
      bus.start = 1'b0;
      wait_done(2, N + 20, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL b2b_timeout done_cnt=%0d required 2", done_cnt); end
      repeat (10) @(negedge Clk);
      #1;
      tests++;
      if (done_cnt != 2 || wr_cnt != 2 * N) begin
         fails++;
         $display("FAIL b2b_counts done=%0d writes=%0d required done=2 writes=%0d", done_cnt, wr_cnt, 2 * N);
      end
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_drain left=%0d required 0", exp_q.size()); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.x0    = '0;
      bus.y0    = '0;
      fork
         monitor();
      join_none
      test_reset();
      test_origin();
      test_offset();
      test_clip();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
